vector_read_unit: RTL and testbench
===================================

Name: vector_read_unit

Overview:
- Parametrised successor to the fixed 20-lane sequential vector reader.
- Fetches a scalar or a vector of up to I items from data memory and assembles them into a lane-indexed output vector.
- Supports a programmable base, stride, element count and memory read latency, with a start/busy/done handshake.
- Sits between the decode/control unit and data memory. It feeds the vector register file (vector_data) and the scalar register file (scalar_data).

Parameters:
- I, 20, number of lanes (max items per vector)
- L, 32, item width in bits
- A, 6, memory address width
- MEM_LAT, 1, cycles from read_en to valid read_data (>=1)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous reset, active-low; sampled on posedge clk
- start  in  1  request pulse; accepted only in IDLE
- op_type  in  1  0 = scalar (one item), 1 = vector
- base_address  in  A  first element address
- stride  in  A  address increment between elements
- length  in  $clog2(I+1)  element count for vector mode; values >I clamp to I
- read_data  in  L  memory read data
- read_en  out  1  memory read strobe
- read_address  out  A  memory read address
- scalar_data  out  L  equals vector_data[0]
- vector_data  out  I*L  packed lanes; lane k = element k
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- error  out  1  bounds fault flag, valid with done

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE; tag pipe flushed.
  - All outputs 0: vector_data, scalar_data, read_en, read_address, busy, done, error.
  - Reset mid-operation aborts the operation; data returning after reset is discarded.
- FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE, start==1:
  - Latch base, stride, op_type and effective length N (N=1 if op_type==0; else min(length,I)).
  - Clear vector_data to 0 and set busy=1.
  - If N==0, go directly to DONE. Otherwise go to ISSUE.
- ISSUE:
  - Issue element k=0..N-1, one per cycle: read_en=1, read_address=(base + k*stride) mod 2^A, with tag {valid,k} pushed into the tag pipe.
  - After k=N-1 is issued, go to DRAIN. read_en=0 outside ISSUE.
- Capture: MEM_LAT cycles after the cycle where read_en is high, read_data is sampled and written to vector_data[tag], tag valid only. Lanes >=N stay 0.
- DRAIN: wait until no valid tag remains in the pipe, then go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. vector_data is final and stable when done is high.
- Latency: for N>=1, done is high N+MEM_LAT+1 edges after the accepting edge; for N==0, 1 edge after.
- start while busy is ignored; no queuing.
- start is accepted again in the cycle after DONE.
- Address arithmetic is A bits; wrap modulo 2^A unless the optional feature is enabled.
- scalar_data is combinational from vector_data[0].

Optional Feature:
- Macro VREAD_BOUNDS_CHECK_EN.
- Defined:
  - Element address is computed in A+$clog2(I)+1 bits.
  - If the unwrapped address for element k is >= 2^A, no read is issued for k or any later element; those lanes stay 0.
  - The FSM moves to DRAIN, and error=1 is asserted together with done.
  - error clears on the next accepted start or on reset.
- Undefined: addresses wrap modulo 2^A; error is held 0.

Decomposition:
- Package vread_pkg:
  - op_t enum (OP_SCALAR=0, OP_VECTOR=1)
  - state_t enum (IDLE, ISSUE, DRAIN, DONE)
  - tag struct {logic valid; logic [$clog2(I)-1:0] idx}
- Sub-module read_tag_pipe:
  - MEM_LAT-deep shift register of tags.
  - Flushed by rst.
  - Provides out_tag and an empty flag.

Test Plan:
- Vector, base=4, stride=1, length=20, MEM_LAT=1, mem[a]=a*3 -> addresses 4..23 issued; vector_data[k]=(4+k)*3; done on edge 22 after start; busy low with done.
- Scalar, op_type=0, base=10, length=7 -> single read at 10; vector_data[0]=scalar_data=mem[10]; lanes 1..19 =0.
- Vector, base=60, stride=3, length=4, macro undefined -> addresses 60,63,2,5; error=0. Same with VREAD_BOUNDS_CHECK_EN -> reads at 60,63 only; lanes 2,3 =0; error=1 with done.
- MEM_LAT=3, length=5, stride=2 -> data captured to correct lanes despite pipelining; done 9 edges after start.
- length=0 vector -> no read_en; done 1 edge later; all lanes 0. A start pulse during busy on another run has no effect.
- rst=0 asserted at element 7 of a 20-element read -> next edge: busy=0, read_en=0, vector_data=0; no late capture; a new start after release works normally.

Source files
------------

// File: rtl/vector_read_unit_pkg.sv
// vread_pkg: shared types for the vector read unit
// Holds the op/state encodings and the in-flight read tag that travels
// alongside each memory request. IDX_W bounds the lane count at 2**IDX_W.
package vread_pkg;
  localparam int IDX_W = 8;
  typedef enum logic {OP_SCALAR = 1'b0, OP_VECTOR = 1'b1} op_t;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
  typedef struct packed {
    logic valid;
    logic [IDX_W-1:0] idx;
  } tag_t;
endpackage

// File: rtl/vector_read_unit_if.sv
// vread_if: control handshake and memory read bus of the vector read unit
// master: requester/memory side (start, op_type, base_address, stride, length, read_data out)
// slave:  the unit (read_en, read_address, scalar_data, vector_data, busy, done, error out)
interface vread_if #(parameter int I = 20, parameter int L = 32, parameter int A = 6);
  localparam int LW = $clog2(I + 1);
  logic start;
  logic op_type;
  logic [A-1:0] base_address;
  logic [A-1:0] stride;
  logic [LW-1:0] length;
  logic [L-1:0] read_data;
  logic read_en;
  logic [A-1:0] read_address;
  logic [L-1:0] scalar_data;
  logic [I*L-1:0] vector_data;
  logic busy;
  logic done;
  logic error;
  modport master(output start, op_type, base_address, stride, length, read_data,
                 input read_en, read_address, scalar_data, vector_data, busy, done, error);
  modport slave(input start, op_type, base_address, stride, length, read_data,
                output read_en, read_address, scalar_data, vector_data, busy, done, error);
endinterface

// File: rtl/vector_read_unit_tag_pipe.sv
// read_tag_pipe: MEM_LAT-deep shift register carrying lane tags beside memory reads
// Ports: clk, rst (sync active-low flush), in_tag (pushed every cycle),
// out_tag (tag matching the current read_data), empty (no tag behind the
// output stage, i.e. the pipe holds nothing once out_tag is consumed).
module read_tag_pipe
  import vread_pkg::*;
#(parameter int MEM_LAT = 1) (
  input  logic clk,
  input  logic rst,
  input  tag_t in_tag,
  output tag_t out_tag,
  output logic empty
);
  tag_t pipe [MEM_LAT];
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < MEM_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= in_tag;
      for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign out_tag = pipe[MEM_LAT-1];
  always_comb begin
    empty = 1'b1;
    for (int i = 0; i < MEM_LAT - 1; i++) empty = empty & ~pipe[i].valid;
  end
endmodule

// File: rtl/vector_read_unit.sv
// vector_read_unit: strided scalar/vector fetch from data memory into lane-indexed vector
// Ports: clk, rst (sync active-low), bus (vread_if.slave: start/op_type/base_address/
// stride/length/read_data in; read_en/read_address/scalar_data/vector_data/busy/done/error out).
// Optional: VREAD_BOUNDS_CHECK_EN stops issuing at the first address past 2**A and flags error.
module vector_read_unit
  import vread_pkg::*;
#(
  parameter int I = 20,
  parameter int L = 32,
  parameter int A = 6,
  parameter int MEM_LAT = 1
) (
  input logic clk,
  input logic rst,
  vread_if.slave bus
);
  localparam int LW = $clog2(I + 1);
`ifdef VREAD_BOUNDS_CHECK_EN
  localparam int W = A + $clog2(I) + 1;
`else
  localparam int W = A;
`endif
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_DONE = DONE;
  logic [1:0] state;
  logic [W-1:0] addr;
  logic [A-1:0] stride_q;
  logic [LW-1:0] n, k, n_eff;
  logic [I*L-1:0] vdata;
  logic fault, oob, issue, pipe_empty, busy_q, done_q, err_q;
  tag_t in_tag, out_tag;
  assign n_eff = bus.op_type == OP_SCALAR ? LW'(1) : (bus.length > LW'(I) ? LW'(I) : bus.length);
`ifdef VREAD_BOUNDS_CHECK_EN
  assign oob = |addr[W-1:A];
`else
  assign oob = 1'b0;
`endif
  assign issue = state == S_ISSUE && !oob;
  assign in_tag = '{valid: issue, idx: IDX_W'(k)};
  assign bus.read_en = issue;
  assign bus.read_address = issue ? addr[A-1:0] : '0;
  assign bus.vector_data = vdata;
  assign bus.scalar_data = vdata[L-1:0];
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.error = err_q;
  read_tag_pipe #(.MEM_LAT(MEM_LAT)) u_tags (
    .clk(clk), .rst(rst), .in_tag(in_tag), .out_tag(out_tag), .empty(pipe_empty)
  );
  // DONE is entered on the edge that consumes the last tag, so done rises one edge later
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      addr <= '0;
      stride_q <= '0;
      n <= '0;
      k <= '0;
      fault <= 1'b0;
      vdata <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      for (int j = 0; j < I; j++)
        if (out_tag.valid && out_tag.idx == IDX_W'(j)) vdata[j*L +: L] <= bus.read_data;
      case (state)
        S_IDLE: if (bus.start) begin
          addr <= W'(bus.base_address);
          stride_q <= bus.stride;
          n <= n_eff;
          k <= '0;
          fault <= 1'b0;
          vdata <= '0;
          busy_q <= 1'b1;
          err_q <= 1'b0;
          state <= n_eff == '0 ? S_DONE : S_ISSUE;
        end
        S_ISSUE: if (oob) begin
          fault <= 1'b1;
          state <= S_DRAIN;
        end else begin
          addr <= addr + W'(stride_q);
          k <= k + LW'(1);
          state <= k == n - LW'(1) ? S_DRAIN : S_ISSUE;
        end
        S_DRAIN: state <= pipe_empty ? S_DONE : S_DRAIN;
        default: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          err_q <= fault;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vector_read_unit.sv
// tb_vector_read_unit: table-driven bench for vector_read_unit (MEM_LAT=1 and MEM_LAT=3 instances)
module tb_vector_read_unit;
  localparam int I = 20;
  localparam int L = 32;
  localparam int A = 6;
  localparam int VW = I * L;

  typedef struct {
    logic op;
    logic [5:0] base;
    logic [5:0] stride;
    logic [4:0] len;
    int nrd;
    int lat;
    logic err;
    int poke;
    string name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vread_if #(.I(I), .L(L), .A(A)) b0();
  vread_if #(.I(I), .L(L), .A(A)) b1();

  vector_read_unit #(.I(I), .L(L), .A(A), .MEM_LAT(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
  vector_read_unit #(.I(I), .L(L), .A(A), .MEM_LAT(3)) u1 (.clk(clk), .rst(rst), .bus(b1));

  function automatic logic [31:0] mf(input logic [5:0] a);
    return 32'(a) * 32'd3;
  endfunction

  function automatic logic [5:0] ea(input logic [5:0] base, input logic [5:0] stride, input int k);
    return 6'(int'(base) + k * int'(stride));
  endfunction

  function automatic logic [VW-1:0] exp_vec(input logic [5:0] base, input logic [5:0] stride, input int n);
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[k*32 +: 32] = mf(ea(base, stride, k));
    return v;
  endfunction

  logic [6:0] mp0;
  logic [6:0] mp1 [3];
  always @(posedge clk) begin
    mp0 <= {b0.read_en, b0.read_address};
    mp1[0] <= {b1.read_en, b1.read_address};
    mp1[1] <= mp1[0];
    mp1[2] <= mp1[1];
  end
  assign b0.read_data = mp0[6] ? mf(mp0[5:0]) : 32'hDEADBEEF;
  assign b1.read_data = mp1[2][6] ? mf(mp1[2][5:0]) : 32'hDEADBEEF;

  logic [5:0] rq0[$];
  always @(negedge clk) if (b0.read_en === 1'b1) rq0.push_back(b0.read_address);

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run0(input vec_t t);
    int lat;
    @(negedge clk);
    b0.op_type = t.op;
    b0.base_address = t.base;
    b0.stride = t.stride;
    b0.length = t.len;
    b0.start = 1'b1;
    rq0.delete();
    @(posedge clk);
    @(negedge clk);
    b0.start = 1'b0;
    lat = 0;
    while (!b0.done && lat < 100) begin
      b0.start = t.poke != 0 && lat == t.poke;
      if (b0.start) begin
        b0.base_address = 6'd30;
        b0.length = 5'd3;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    b0.start = 1'b0;
    chk({t.name, " latency"}, VW'(lat), VW'(t.lat));
    chk({t.name, " reads"}, VW'(rq0.size()), VW'(t.nrd));
    for (int k = 0; k < t.nrd && k < rq0.size(); k++)
      chk($sformatf("%s addr%0d", t.name, k), VW'(rq0[k]), VW'(ea(t.base, t.stride, k)));
    chk({t.name, " vector"}, b0.vector_data, exp_vec(t.base, t.stride, t.nrd));
    chk({t.name, " scalar"}, VW'(b0.scalar_data), VW'(t.nrd > 0 ? mf(t.base) : 32'd0));
    chk({t.name, " error"}, VW'(b0.error), VW'(t.err));
    chk({t.name, " busy@done"}, VW'(b0.busy), VW'(0));
    @(posedge clk);
    @(negedge clk);
    chk({t.name, " done pulse"}, VW'(b0.done), VW'(0));
  endtask

  initial begin
    vec_t tv[7];
    int lat;
    #10_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[7];
    int lat;
    tv[0] = '{1'b1, 6'd4, 6'd1, 5'd20, 20, 22, 1'b0, 0, "vec20"};
    tv[1] = '{1'b0, 6'd10, 6'd5, 5'd7, 1, 3, 1'b0, 0, "scalar"};
`ifdef VREAD_BOUNDS_CHECK_EN
    tv[2] = '{1'b1, 6'd60, 6'd3, 5'd4, 2, 5, 1'b1, 0, "bounds"};
`else
    tv[2] = '{1'b1, 6'd60, 6'd3, 5'd4, 4, 6, 1'b0, 0, "wrap"};
`endif
    tv[3] = '{1'b1, 6'd7, 6'd1, 5'd0, 0, 1, 1'b0, 0, "len0"};
    tv[4] = '{1'b1, 6'd0, 6'd2, 5'd25, 20, 22, 1'b0, 0, "clamp"};
    tv[5] = '{1'b1, 6'd50, 6'd5, 5'd3, 3, 5, 1'b0, 0, "vec3"};
    tv[6] = '{1'b1, 6'd4, 6'd1, 5'd20, 20, 22, 1'b0, 5, "poke"};
    b0.start = 1'b0; b0.op_type = 1'b0; b0.base_address = '0; b0.stride = '0; b0.length = '0;
    b1.start = 1'b0; b1.op_type = 1'b0; b1.base_address = '0; b1.stride = '0; b1.length = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst vector", b0.vector_data, '0);
    chk("rst scalar", VW'(b0.scalar_data), '0);
    chk("rst read_en", VW'(b0.read_en), '0);
    chk("rst read_address", VW'(b0.read_address), '0);
    chk("rst busy", VW'(b0.busy), '0);
    chk("rst done", VW'(b0.done), '0);
    chk("rst error", VW'(b0.error), '0);
    rst = 1'b1;
    for (int i = 0; i < 7; i++) run0(tv[i]);

    // reset while element 7 of a 20-element read is being issued
    @(negedge clk);
    b0.op_type = 1'b1; b0.base_address = 6'd4; b0.stride = 6'd1; b0.length = 5'd20; b0.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b0.start = 1'b0;
    repeat (7) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("mid addr7", VW'(b0.read_address), VW'(11));
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort busy", VW'(b0.busy), '0);
    chk("abort read_en", VW'(b0.read_en), '0);
    chk("abort vector", b0.vector_data, '0);
    chk("abort done", VW'(b0.done), '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("no late capture", b0.vector_data, '0);
    chk("idle after abort", VW'(b0.busy), '0);
    run0(tv[0]);

    // deeper memory latency on the second instance
    @(negedge clk);
    b1.op_type = 1'b1; b1.base_address = 6'd1; b1.stride = 6'd2; b1.length = 5'd5; b1.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b1.start = 1'b0;
    lat = 0;
    while (!b1.done && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("lat3 latency", VW'(lat), VW'(9));
    chk("lat3 vector", b1.vector_data, exp_vec(6'd1, 6'd2, 5));
    chk("lat3 error", VW'(b1.error), '0);
    chk("lat3 busy@done", VW'(b1.busy), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
